// File: rtl/uart_rx_port.sv
// 16x-oversampled 8N1 UART receiver exposed as a data/status register pair.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise one holding register.
module uart_rx_port #(
  parameter logic [10:0] DATA_ADDR  = 11'd102,
  parameter logic [10:0] STAT_ADDR  = 11'd103,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxclk_en,
  input  logic        rx,
  input  logic [10:0] m_addr,
  input  logic        m_rd,
  input  logic        m_en,
  output logic [7:0]  rd_data,
  output logic        rd_hit,
  output logic        irq
);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_rx_port: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        push, frame_set;

  logic        full, avail, pop, do_push, overrun_set, stat_clr;
  logic [7:0]  head, head_data, status, live_data, hold_q;
  logic        frame_err_q, overrun_q, hit_q, irq_q, acc_start;
  logic        is_data, is_stat;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (rxclk_en) begin
      cnt_d = cnt_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!rx_s_q) state_d = S_START;
        end
        S_START: if (cnt_q == 4'd7) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end
        S_DATA: if (cnt_q == 4'd15) begin
          shreg_d = {rx_s_q, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
        S_STOP: if (cnt_q == 4'd15) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    push      = 1'b0;
    frame_set = 1'b0;
    if (state_q == S_STOP && rxclk_en && cnt_q == 4'd15) begin
      push      = rx_s_q;
      frame_set = !rx_s_q;
    end
  end

  // A pop or flag clear acts only on the first cycle of a CPU access.
  assign is_data   = (m_addr == DATA_ADDR);
  assign is_stat   = (m_addr == STAT_ADDR);
  assign rd_hit    = m_en & m_rd & (is_data | is_stat);
  assign acc_start = rd_hit & ~hit_q;
  assign pop       = acc_start & is_data & avail;
  assign stat_clr  = acc_start & is_stat;

  // A full buffer still accepts a push when the head leaves on the same edge.
  assign do_push     = push & (~full | pop);
  assign overrun_set = push & full & ~pop;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign avail = (wr_ptr_q != rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  // NOTE: storage is left unreset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      irq_q    <= (wr_ptr_d != rd_ptr_d);
    end
  end
`else
  logic [7:0] hold_byte_q;
  logic       valid_q, valid_d;

  assign full    = valid_q;
  assign avail   = valid_q;
  assign head    = hold_byte_q;
  assign valid_d = do_push | (valid_q & ~pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_byte_q <= '0;
      valid_q     <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (do_push) hold_byte_q <= shreg_q;
      valid_q <= valid_d;
      irq_q   <= valid_d;
    end
  end
`endif

  assign head_data = avail ? head : 8'h00;
  assign status    = {5'b0, frame_err_q, overrun_q, avail};
  assign live_data = is_data ? head_data : status;
  assign rd_data   = !rd_hit ? 8'h00 : (acc_start ? live_data : hold_q);
  assign irq       = irq_q;

  // Setting a flag takes priority over a same-cycle status-read clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      hit_q       <= 1'b0;
      hold_q      <= '0;
    end else begin
      if (frame_set)        frame_err_q <= 1'b1;
      else if (stat_clr)    frame_err_q <= 1'b0;
      if (overrun_set)      overrun_q   <= 1'b1;
      else if (stat_clr)    overrun_q   <= 1'b0;
      hit_q <= rd_hit;
      if (acc_start) hold_q <= live_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port: serial frames are driven bit by bit and a
// byte-queue model of the receive buffer supplies every expected register value.
module tb_uart_rx_port;

  localparam logic [10:0] DATA_ADDR = 11'd102;
  localparam logic [10:0] STAT_ADDR = 11'd103;
`ifdef UART_RX_FIFO_EN
  localparam int MODEL_DEPTH = 4;
`else
  localparam int MODEL_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rxclk_en = 1'b0;
  logic        rx = 1'b1;
  logic [10:0] m_addr = '0;
  logic        m_rd = 1'b0;
  logic        m_en = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_hit;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  int tick_div = 0;

  logic [7:0] exp_q[$];
  logic       exp_frame = 1'b0;
  logic       exp_ovr = 1'b0;

  uart_rx_port #(
    .DATA_ADDR (DATA_ADDR),
    .STAT_ADDR (STAT_ADDR),
    .FIFO_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rxclk_en(rxclk_en),
    .rx      (rx),
    .m_addr  (m_addr),
    .m_rd    (m_rd),
    .m_en    (m_en),
    .rd_data (rd_data),
    .rd_hit  (rd_hit),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // 16x strobe: one clk wide, every fourth clk.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rxclk_en = (tick_div == 3);
      tick_div = (tick_div + 1) % 4;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!rxclk_en) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic b);
    #1 rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    wait_ticks(1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    #1 rx = 1'b1;
    if (stop_ok) begin
      if (exp_q.size() < MODEL_DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end else begin
      exp_frame = 1'b1;
    end
  endtask

  task automatic cpu_read(input logic [10:0] addr, output logic [7:0] d, output logic hit);
    @(posedge clk);
    #1;
    m_addr = addr;
    m_rd   = 1'b1;
    m_en   = 1'b1;
    @(negedge clk);
    d   = rd_data;
    hit = rd_hit;
    @(posedge clk);
    #1;
    m_rd = 1'b0;
    m_en = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [7:0] d, e;
    logic       h;
    cpu_read(DATA_ADDR, d, h);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    check(tag, d, e);
  endtask

  task automatic read_status(input string tag);
    logic [7:0] d, e;
    logic       h;
    e = {5'b0, exp_frame, exp_ovr, exp_q.size() != 0};
    cpu_read(STAT_ADDR, d, h);
    check(tag, d, e);
    exp_frame = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic check_irq(input string tag);
    @(negedge clk);
    check(tag, {7'b0, irq}, {7'b0, exp_q.size() != 0});
  endtask

  initial begin
    logic [7:0] d;
    logic       h;

    // Reset state.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_rd_hit", {7'b0, rd_hit}, 8'h00);
    check("reset_irq", {7'b0, irq}, 8'h00);
    cpu_read(STAT_ADDR, d, h);
    check("reset_status", d, 8'h00);
    check("rd_hit_on_access", {7'b0, h}, 8'h01);
    cpu_read(11'd101, d, h);
    check("miss_rd_data", d, 8'h00);
    check("miss_rd_hit", {7'b0, h}, 8'h00);

    // Single byte.
    send_frame(8'h55, 1'b1);
    check_irq("single_irq_set");
    read_status("single_status");
    read_data("single_data");
    read_status("single_status_after");
    check_irq("single_irq_clear");

    // Glitch rejection.
    wait_ticks(1);
    #1 rx = 1'b0;
    wait_ticks(4);
    #1 rx = 1'b1;
    wait_ticks(20);
    read_status("glitch_status");
    check_irq("glitch_irq");
    read_data("glitch_data");

    // Framing error.
    send_frame(8'hA3, 1'b0);
    wait_ticks(20);
    read_status("frame_status");
    read_data("frame_data");
    read_status("frame_status_again");

    // Overrun.
`ifdef UART_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
`else
    for (int i = 1; i <= 2; i++) send_frame(8'(i), 1'b1);
`endif
    check_irq("ovr_irq");
    read_status("ovr_status");
    for (int i = 0; i <= MODEL_DEPTH; i++) read_data($sformatf("ovr_data_%0d", i));
    read_status("ovr_status_after");
    check_irq("ovr_irq_clear");

    // Assorted byte patterns.
    for (int i = 0; i < 4; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
      read_data($sformatf("rand_data_%0d", i));
    end
    send_frame(8'hFF, 1'b1);
    read_data("all_ones_data");
    send_frame(8'h00, 1'b1);
    read_data("all_zeros_data");

    // Held read: one pop, stable data across the access.
    send_frame(8'h11, 1'b1);
`ifdef UART_RX_FIFO_EN
    send_frame(8'h22, 1'b1);
`endif
    @(posedge clk);
    #1;
    m_addr = DATA_ADDR;
    m_rd   = 1'b1;
    m_en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("held_data_%0d", i), rd_data, exp_q[0]);
      @(posedge clk);
    end
    #1;
    m_rd = 1'b0;
    m_en = 1'b0;
    void'(exp_q.pop_front());
    check_irq("held_irq");
`ifndef UART_RX_FIFO_EN
    send_frame(8'h22, 1'b1);
`endif
    read_data("held_next_data");

    // Reset mid-frame with a byte buffered and a flag pending.
    send_frame(8'hA3, 1'b0);
    wait_ticks(20);
    send_frame(8'h77, 1'b1);
    check_irq("pre_reset_irq");
    wait_ticks(1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    #1 rx = 1'b1;
    wait_ticks(8);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    exp_frame = 1'b0;
    exp_ovr   = 1'b0;
    check_irq("midreset_irq");
    wait_ticks(20);
    read_status("midreset_status");
    read_data("midreset_data");
    send_frame(8'h3C, 1'b1);
    read_data("midreset_next_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_port.md
# uart_rx_port

Memory-mapped UART receiver for the NoobsCPU SoC, the receive-side counterpart of the existing TX path. It oversamples the asynchronous `rx` line using the 16x `rxclk_en` strobe from the baud-rate generator and deframes 8N1 characters. Received bytes are buffered and exposed to the CPU on two data-memory addresses: a data register and a status register. The SoC read mux selects `rd_data` whenever `rd_hit` is high.

## Interface
Parameters:
- `DATA_ADDR`, 11'd102: data register address; a read pops one byte.
- `STAT_ADDR`, 11'd103: status register address; a read clears the sticky error flags.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of 2, ≥2. Used only with `UART_RX_FIFO_EN`.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `rxclk_en`  in  1  one-cycle pulse at 16x baud.
- `rx`  in  1  asynchronous serial input; idles high.
- `m_addr`  in  11  CPU data address.
- `m_rd`  in  1  CPU read strobe.
- `m_en`  in  1  CPU memory enable.
- `rd_data`  out  8  read data; valid while `rd_hit` is high, otherwise 0x00.
- `rd_hit`  out  1  `m_en & m_rd & (m_addr==DATA_ADDR | m_addr==STAT_ADDR)`; combinational.
- `irq`  out  1  registered; high while at least one byte is buffered.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1.
- **Sampling:** the FSM uses a 4-bit tick counter `cnt` that advances only on `rxclk_en`, and a 3-bit bit index.
- **IDLE:** on `rxclk_en` with `rx_s==0`, set `cnt=0` and go to START.
- **START:** at `cnt==7` (mid start bit):
  - if `rx_s==0`, set `cnt=0`, index=0, go to DATA;
  - otherwise this is a false start; return to IDLE with no side effects.
- **DATA:** at `cnt==15`, shift `rx_s` into the shift register LSB-first. After 8 bits, go to STOP.
- **STOP:** at `cnt==15`:
  - if `rx_s==1`, push the byte;
  - if `rx_s==0`, discard the byte and set `frame_err`.
  - Go to IDLE on the same tick. Back-to-back frames are accepted.
- **Push into a full buffer:** the byte is dropped, the buffer is unchanged, and `overrun` is set.
- **Status byte:** `{5'b0, frame_err, overrun, avail}`, where `avail` = buffer not empty.
- **Data read:** `rd_data` = buffer head; empty returns 0x00.
- **Access start:** a pop or a flag clear happens only on the first cycle of an access, i.e. the hit is asserted and was not asserted the previous cycle. A multi-cycle `m_rd` therefore pops once, and `rd_data` stays stable for the whole access.
- **Simultaneous events:**
  - push and pop in the same cycle while full: both succeed, count unchanged, no overrun;
  - flag set and status-read clear in the same cycle: set wins.

## Timing
- **Reset values:** `rd_data`=0x00, `rd_hit`=0, `irq`=0. State is IDLE, buffer empty, flags 0, synchronizer 1s.
- **Reset mid-frame:** abandons the frame and empties the buffer in the same cycle.
- **Detection latency:** a start edge is detected 2–3 `clk` after `rx` falls (synchronizer) plus up to one `rxclk_en` period.
- **Byte availability:** the byte appears in the buffer, and `avail`/`irq` rise, one `clk` after the `rxclk_en` that samples the stop bit.
- **Read path:** combinational from `m_addr`/`m_rd`/`m_en`.
- **Pop effect:** the pop takes effect at the clock edge ending the first access cycle; `irq` updates on that same edge.
- **Pointers:** FIFO pointers are log2(`FIFO_DEPTH`)+1 bits and wrap naturally. Full when the MSBs differ and the rest match; empty when equal.

## Configuration
- **`UART_RX_FIFO_EN` defined:** `FIFO_DEPTH`-entry circular FIFO as described.
- **Not defined:** a single 8-bit holding register plus a valid bit replaces the FIFO.
  - Full = valid.
  - A push while valid sets `overrun` and keeps the old byte.
  - All other behaviour is identical.

## Test plan
- **Single byte:** send 0x55 (16 ticks/bit) → status reads 0x01, `irq`=1. Data read returns 0x55; the next status read returns 0x00, `irq`=0.
- **Glitch rejection:** drive `rx` low for 4 ticks, then high → FSM back in IDLE, status 0x00, nothing buffered.
- **Framing error:** send 0xA3 with stop bit 0 → status 0x04, data read 0x00. A second status read returns 0x00.
- **Overrun:** send 0x01..0x05 without reading.
  - With FIFO (depth 4): data reads return 0x01..0x04, then 0x00; status before the reads is 0x03.
  - Without FIFO: send 0x01, 0x02 → data 0x01, status before the read 0x03.
- **Held read:** queue 0x11 and 0x22, then hold `m_rd`/`m_en` on `DATA_ADDR` for 3 cycles → `rd_data`=0x11 throughout with a single pop. The next access returns 0x22.
- **Reset mid-frame:** assert `reset` for one cycle during data bit 3 → flags 0, buffer empty, `irq`=0. A following full frame of 0x3C reads back 0x3C.
